// File: rtl/layer_serializer.sv
// Parallel-to-serial bridge between neuron layers: captures a complete result
// vector, then streams it out one word per beat with optional idle gaps.
module layer_serializer #(
  parameter int NN        = 6,
  parameter int dataWidth = 16,
  parameter int GAP       = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NN-1:0]             i_valid,
  input  logic [NN*dataWidth-1:0]   i_data,
  output logic                      o_valid,
  output logic [dataWidth-1:0]      o_data,
  output logic                      o_last,
  output logic                      busy,
  output logic                      overrun,
  output logic                      skew_err
);

  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);
  localparam bit            HAS_GAP  = (GAP > 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 overrun_q, overrun_d;
  logic                 skew_q, skew_d;
  logic                 capture;
  logic [dataWidth-1:0] hold_q [NN];
  logic [dataWidth-1:0] word_in [NN];

  logic all_valid;
  logic any_valid;
  logic is_last;

  assign all_valid = &i_valid;
  assign any_valid = |i_valid;
  assign is_last   = (idx_q == IDX_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < NN; gi++) begin : g_unpack
      assign word_in[gi] = i_data[gi*dataWidth +: dataWidth];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    capture   = 1'b0;
    overrun_d = overrun_q;
    // A partially valid vector is a protocol error and never captured.
    skew_d    = skew_q | (any_valid & ~all_valid);

    case (state_q)
      S_IDLE: begin
        if (all_valid) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (is_last) begin
          idx_d = '0;
          // Accepting on the last beat keeps o_valid continuous across vectors.
          if (all_valid) begin
            capture = 1'b1;
            state_d = S_SEND;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if (all_valid) begin
            overrun_d = 1'b1;
          end
          idx_d = idx_q + 1'b1;
          if (HAS_GAP) begin
            gap_d   = '0;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (all_valid) begin
          overrun_d = 1'b1;
        end
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_SEND;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      gap_q     <= '0;
      overrun_q <= 1'b0;
      skew_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      overrun_q <= overrun_d;
      skew_q    <= skew_d;
    end
  end

  // Holding register has no reset: its contents only matter after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < NN; k++) begin
        hold_q[k] <= word_in[k];
      end
    end
  end

  assign o_valid  = (state_q == S_SEND);
  assign o_data   = o_valid ? hold_q[idx_q] : '0;
  assign o_last   = o_valid & is_last;
  assign busy     = (state_q != S_IDLE);
  assign overrun  = overrun_q;
  assign skew_err = skew_q;

endmodule

// File: tb/tb_layer_serializer.sv
// Bench for layer_serializer: a directed cycle table, an explicit GAP=2 timing
// sequence and random traffic, all checked against a timeline-based model.
module tb_layer_serializer;

  localparam int NN = 6;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NN-1:0]     i_valid;
  logic [NN*DW-1:0]  i_data;

  logic          ov0, ol0, ob0, oo0, os0;
  logic [DW-1:0] od0;
  logic          ov2, ol2, ob2, oo2, os2;
  logic [DW-1:0] od2;

  layer_serializer #(.NN(NN), .dataWidth(DW), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
    .o_valid(ov0), .o_data(od0), .o_last(ol0), .busy(ob0),
    .overrun(oo0), .skew_err(os0)
  );

  layer_serializer #(.NN(NN), .dataWidth(DW), .GAP(2)) u_g2 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
    .o_valid(ov2), .o_data(od2), .o_last(ol2), .busy(ob2),
    .overrun(oo2), .skew_err(os2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          r;
    logic [5:0]  vld;
    logic [15:0] base;
    bit          ev;
    logic [15:0] ed;
    bit          el, eb, eo, es;
  } row_t;

  row_t rows[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   model_on = 1'b0;

  // Model: each instance holds at most one live vector, described by its
  // capture cycle; emission times follow T+1+k*(GAP+1).
  int          gapv  [2] = '{0, 2};
  bit          cur_v [2];
  int          cur_t [2];
  logic [15:0] cur_d [2][NN];
  bit          ovr_m [2];
  bit          skw_m [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int last_cycle(input int g);
    return cur_t[g] + 1 + (NN - 1) * (gapv[g] + 1);
  endfunction

  task automatic model_check(input int g);
    bit ev, el, eb;
    logic [15:0] ed;
    int off, k;
    ev = 0; el = 0; eb = 0; ed = '0;
    if (cur_v[g] && cyc > cur_t[g] && cyc <= last_cycle(g)) begin
      eb  = 1;
      off = cyc - cur_t[g] - 1;
      if (off % (gapv[g] + 1) == 0) begin
        k  = off / (gapv[g] + 1);
        ev = 1;
        ed = cur_d[g][k];
        el = (k == NN - 1);
      end
    end
    if (g == 0) begin
      chk("g0_valid", 32'(ov0), 32'(ev)); chk("g0_data", 32'(od0), 32'(ed));
      chk("g0_last", 32'(ol0), 32'(el));  chk("g0_busy", 32'(ob0), 32'(eb));
      chk("g0_overrun", 32'(oo0), 32'(ovr_m[0])); chk("g0_skew", 32'(os0), 32'(skw_m[0]));
    end else begin
      chk("g2_valid", 32'(ov2), 32'(ev)); chk("g2_data", 32'(od2), 32'(ed));
      chk("g2_last", 32'(ol2), 32'(el));  chk("g2_busy", 32'(ob2), 32'(eb));
      chk("g2_overrun", 32'(oo2), 32'(ovr_m[1])); chk("g2_skew", 32'(os2), 32'(skw_m[1]));
    end
  endtask

  task automatic model_edge(input int g);
    if (rst) begin
      cur_v[g] = 0; ovr_m[g] = 0; skw_m[g] = 0;
    end else begin
      if (i_valid != '0 && i_valid != '1) skw_m[g] = 1;
      if (i_valid == '1) begin
        if (!cur_v[g] || cyc >= last_cycle(g)) begin
          cur_v[g] = 1;
          cur_t[g] = cyc;
          for (int k = 0; k < NN; k++) cur_d[g][k] = i_data[k*DW +: DW];
        end else begin
          ovr_m[g] = 1;
        end
      end
    end
  endtask

  task automatic drive(input bit r, input logic [5:0] v, input logic [15:0] base, input bit rnd);
    rst     = r;
    i_valid = v;
    for (int k = 0; k < NN; k++)
      i_data[k*DW +: DW] = rnd ? 16'($urandom) : base + 16'(k);
  endtask

  // One clock: outputs checked mid-cycle, then the model absorbs this edge.
  task automatic step(input row_t e, input int chk_g);
    @(negedge clk);
    if (model_on) begin
      model_check(0);
      model_check(1);
    end
    if (chk_g == 0) begin
      chk("row_valid", 32'(ov0), 32'(e.ev)); chk("row_data", 32'(od0), 32'(e.ed));
      chk("row_last", 32'(ol0), 32'(e.el));  chk("row_busy", 32'(ob0), 32'(e.eb));
      chk("row_overrun", 32'(oo0), 32'(e.eo)); chk("row_skew", 32'(os0), 32'(e.es));
    end else if (chk_g == 2) begin
      chk("gap_valid", 32'(ov2), 32'(e.ev)); chk("gap_data", 32'(od2), 32'(e.ed));
      chk("gap_last", 32'(ol2), 32'(e.el));  chk("gap_busy", 32'(ob2), 32'(e.eb));
    end
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic row_t mk(bit r, logic [5:0] vld, logic [15:0] base,
                              bit ev, logic [15:0] ed, bit el, bit eb, bit eo, bit es);
    row_t x;
    x.r = r; x.vld = vld; x.base = base;
    x.ev = ev; x.ed = ed; x.el = el; x.eb = eb; x.eo = eo; x.es = es;
    return x;
  endfunction

  row_t none;

  initial begin
    none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      cur_v[k] = 0; cur_t[k] = 0; ovr_m[k] = 0; skw_m[k] = 0;
    end

    //           rst vld    base      ev ed       el eb eo es
    rows.push_back(mk(0, 6'h3F, 16'h0100, 0, 16'h0000, 0, 0, 0, 0));
    rows.push_back(mk(0, 6'h00, 16'hDEAD, 1, 16'h0100, 0, 1, 0, 0));
    rows.push_back(mk(0, 6'h00, 16'hBEEF, 1, 16'h0101, 0, 1, 0, 0));
    rows.push_back(mk(0, 6'h00, 16'h1234, 1, 16'h0102, 0, 1, 0, 0));
    rows.push_back(mk(0, 6'h00, 16'h5555, 1, 16'h0103, 0, 1, 0, 0));
    rows.push_back(mk(0, 6'h00, 16'hAAAA, 1, 16'h0104, 0, 1, 0, 0));
    rows.push_back(mk(0, 6'h3F, 16'h0200, 1, 16'h0105, 1, 1, 0, 0));
    rows.push_back(mk(0, 6'h00, 16'hF00F, 1, 16'h0200, 0, 1, 0, 0));
    rows.push_back(mk(0, 6'h00, 16'h0F0F, 1, 16'h0201, 0, 1, 0, 0));
    rows.push_back(mk(0, 6'h3F, 16'h0300, 1, 16'h0202, 0, 1, 0, 0));
    rows.push_back(mk(0, 6'h00, 16'h7777, 1, 16'h0203, 0, 1, 1, 0));
    rows.push_back(mk(0, 6'h00, 16'h8888, 1, 16'h0204, 0, 1, 1, 0));
    rows.push_back(mk(0, 6'h00, 16'h9999, 1, 16'h0205, 1, 1, 1, 0));
    rows.push_back(mk(0, 6'h00, 16'h0300, 0, 16'h0000, 0, 0, 1, 0));
    rows.push_back(mk(0, 6'h07, 16'h0600, 0, 16'h0000, 0, 0, 1, 0));
    rows.push_back(mk(0, 6'h00, 16'h0000, 0, 16'h0000, 0, 0, 1, 1));
    rows.push_back(mk(1, 6'h00, 16'h0000, 0, 16'h0000, 0, 0, 1, 1));
    rows.push_back(mk(0, 6'h3F, 16'h0400, 0, 16'h0000, 0, 0, 0, 0));
    rows.push_back(mk(0, 6'h00, 16'h1111, 1, 16'h0400, 0, 1, 0, 0));
    rows.push_back(mk(0, 6'h00, 16'h2222, 1, 16'h0401, 0, 1, 0, 0));
    rows.push_back(mk(1, 6'h00, 16'h3333, 1, 16'h0402, 0, 1, 0, 0));
    rows.push_back(mk(0, 6'h00, 16'h4444, 0, 16'h0000, 0, 0, 0, 0));
    rows.push_back(mk(0, 6'h3F, 16'h0500, 0, 16'h0000, 0, 0, 0, 0));
    for (int k = 0; k < NN; k++)
      rows.push_back(mk(0, 6'h00, 16'hC0DE, 1, 16'h0500 + 16'(k), k == NN - 1, 1, 0, 0));
    rows.push_back(mk(0, 6'h00, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));

    // Initial reset; outputs are unknown before the first edge.
    drive(1, 0, 0, 0);
    @(posedge clk); #1; cyc++;
    model_edge(0); model_edge(1);
    model_on = 1'b1;
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    drive(0, 0, 0, 0);

    foreach (rows[i]) begin
      drive(rows[i].r, rows[i].vld, rows[i].base, 0);
      step(rows[i], 0);
    end

    // Let the GAP=2 instance drain, then check its beat spacing explicitly.
    drive(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(none, -1);
    drive(0, 6'h3F, 16'h0100, 0);
    step(none, -1);
    for (int i = 1; i <= 17; i++) begin
      row_t e;
      e = mk(0, 0, 0, ((i - 1) % 3 == 0) && i <= 16,
             (((i - 1) % 3 == 0) && i <= 16) ? 16'h0100 + 16'((i - 1) / 3) : 16'h0000,
             i == 16, i <= 16, 0, 0);
      drive(0, 0, 0, 1);
      step(e, 2);
    end

    // Random traffic: mostly idle, frequent full vectors, some skew and resets.
    for (int i = 0; i < 800; i++) begin
      int sel;
      logic [5:0] v;
      sel = int'($urandom_range(0, 99));
      if (sel < 25)      v = 6'h3F;
      else if (sel < 30) v = 6'($urandom_range(1, 62));
      else               v = 6'h00;
      drive($urandom_range(0, 79) == 0, v, 16'h0000, 1);
      step(none, -1);
    end

    drive(0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_serializer.md
# layer_serializer

Converts the parallel output vector of one neuron layer (NN results, one `dataWidth` word each, with per-neuron valid bits) into the serial one-word-per-beat `x_valid`/`x_in` stream that the next layer's neurons consume. It sits between consecutive layers in the network pipeline. It captures a complete result vector, emits neuron 0 first, and flags protocol violations with sticky error bits.

## Interface
- `NN`, 6, number of neurons in the upstream layer (words per vector), ≥2
- `dataWidth`, 16, width of one neuron result
- `GAP`, 0, idle cycles inserted between consecutive output words (0 = back-to-back)

Ports:
- `clk`  in  1  single clock; all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `i_valid`  in  NN  per-neuron result valid from upstream layer
- `i_data`  in  NN*dataWidth  upstream results; neuron k at `[k*dataWidth +: dataWidth]`
- `o_valid`  out  1  serial word valid (drives next layer `x_valid`)
- `o_data`  out  dataWidth  serial word (drives next layer `x_in`)
- `o_last`  out  1  high with the final word (neuron NN-1) of a vector
- `busy`  out  1  vector held, emission in progress
- `overrun`  out  1  sticky: a vector arrived while busy and was dropped
- `skew_err`  out  1  sticky: `i_valid` non-zero but not all-ones in a cycle

## Operation
- States: IDLE, SEND, WAIT.
- Capture condition: `&i_valid` sampled high on a clock edge while in IDLE, or in SEND on the cycle emitting the last word (back-to-back acceptance). On capture, all NN words are copied into an internal holding register. The word index is set to 0 and the state goes to SEND.
- SEND: drive `o_valid`=1 and `o_data`=held word[idx].
  - If idx==NN-1: `o_last`=1. Go to IDLE, or stay in SEND with idx=0 if a back-to-back capture occurs this cycle.
  - Else: idx+1. Go to WAIT if GAP>0, otherwise stay in SEND.
- WAIT: `o_valid`=0. The gap counter counts GAP cycles, then returns to SEND.
- `&i_valid` high in SEND (not on the last word) or in WAIT: the vector is dropped, `overrun` is set, and the current emission continues unaffected.
- `i_valid` != 0 and != all-ones in any cycle sets `skew_err`. No capture occurs.
- Sticky bits are cleared only by `rst`.
- `o_data` is 0 whenever `o_valid`=0. Data passes through unmodified: no sign or width change.
- The holding register is loaded only on capture. Upstream may change `i_data` freely after the capture cycle.

## Timing
- Reset: `o_valid`=0, `o_data`=0, `o_last`=0, `busy`=0, `overrun`=0, `skew_err`=0. State is IDLE, idx=0, gap counter=0. The holding register contents are don't-care.
- `rst` asserted mid-vector aborts the vector at the next edge. No further words are emitted and all outputs return to their reset values.
- For a capture edge at cycle T, word k appears at cycle T+1+k*(GAP+1). The first-word latency is 1 cycle.
- `o_last` coincides with word NN-1 at T+1+(NN-1)*(GAP+1).
- `busy`=1 from T+1 through the `o_last` cycle inclusive. It stays 1 on a back-to-back capture.
- With GAP=0 and back-to-back vectors, `o_valid` stays high continuously and the next vector's word 0 follows the previous `o_last` with no bubble.
- `overrun`/`skew_err` go high the cycle after the offending sample edge.

## Test plan
- NN=6, GAP=0: present a vector with word k = 0x0100+k and `i_valid`=6'b111111 for 1 cycle. Expect `o_valid` for 6 consecutive cycles carrying 0x0100..0x0105, `o_last` only with 0x0105, and `busy` 6 cycles.
- GAP=2: the same vector gives words at T+1, T+4, T+7, T+10, T+13, T+16, with `o_valid` low in between and `o_last` at T+16.
- Back-to-back: a second vector (0x0200+k) captured on the `o_last` cycle of the first. Expect 12 contiguous valid words 0x0100..0x0105 then 0x0200..0x0205, and `overrun` stays 0.
- Overrun: a second vector asserted at T+3 (mid-send). Expect the first vector to complete intact, the second to be never emitted, `overrun`=1 from T+4, and `overrun` to remain 1 until `rst`.
- Skew: `i_valid`=6'b000111 for 1 cycle. Expect no output words, `skew_err`=1 the next cycle, and `busy`=0.
- Reset mid-operation: `rst` pulsed at T+3. Expect all outputs 0 from T+4, no further words, and sticky bits cleared. A fresh vector afterwards serializes normally.
